// File: rtl/zircon_segled_pkg.sv
// Shared definitions for the Zircon segment-LED scan controller.
// Latency: n/a (constants and a combinational decode function).
// Backpressure: n/a.
// Contents: register address constants, digit/control field positions, hex_to_seg.
package zircon_segled_pkg;

  // Register map (digit registers occupy 0..DIGITS-1)
  localparam logic [3:0] ADDR_CTRL = 4'd8;
  localparam logic [3:0] ADDR_STAT = 4'd9;

  // Digit register fields
  localparam int DIG_VAL_MSB   = 3;
  localparam int DIG_DP_BIT    = 4;
  localparam int DIG_BLANK_BIT = 5;
  localparam logic [5:0] DIG_RESET = 6'h0F;  // visible, no dp, shows "F"

  // Control register fields
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_TEST_BIT = 1;

  // Logical (active-high) segment pattern, bit 0 = a ... bit 6 = g
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/zircon_segled_scan.sv
// Scan timebase: prescaler dwelling SCAN_DIV cycles per digit, then advancing the digit index.
// Latency: index changes on the edge where the prescaler wraps; tick is combinational.
// Backpressure: none; enable=0 parks the prescaler at 0 and freezes the index.
// Ports: clk, reset (sync, active-high), enable, index[2:0] out, tick out (last dwell cycle).
module zircon_segled_scan #(
  parameter int DIGITS   = 6,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [2:0] index,
  output logic       tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0]    INDEX_LAST = 3'(DIGITS - 1);

  logic [PW-1:0] presc;

  assign tick = enable && (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      index <= '0;
    end else if (!enable) begin
      // Parking at 0 gives a full dwell when scanning resumes.
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
      index <= (index == INDEX_LAST) ? 3'd0 : index + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/zircon_avalon_segled_scan.sv
// Avalon-MM seven-segment controller: digit/control registers, scan, decode, registered pin drive.
// Latency: readdata 1 cycle after read; pins reflect register/index state 1 cycle later.
// Backpressure: none; no waitrequest, every access completes in its cycle.
// Ports: csi_clk, rsi_reset, avs_address/write/writedata/read/readdata, coe_seg[7:0], coe_sel[DIGITS-1:0].
module zircon_avalon_segled_scan #(
  parameter int DIGITS         = 6,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic              csi_clk,
  input  logic              rsi_reset,
  input  logic [3:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [7:0]        coe_seg,
  output logic [DIGITS-1:0] coe_sel
);

  import zircon_segled_pkg::*;

  localparam logic [3:0]        DIGITS_A = 4'(DIGITS);
  localparam logic [7:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF  = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Eight slots always exist; slots at or above DIGITS keep their reset value.
  logic [5:0]        digit_q [8];
  logic              ctrl_en;
  logic              ctrl_test;
  logic [2:0]        index;
  logic              scan_tick;
  logic [31:0]       rd_mux;
  logic [5:0]        cur_digit;
  logic [DIGITS-1:0] sel_onehot;
  logic [7:0]        seg_log;
  logic [DIGITS-1:0] sel_log;
  logic [7:0]        seg_d;
  logic [DIGITS-1:0] sel_d;
  logic              unused_bits;

  assign unused_bits = ^{avs_writedata[31:DIG_BLANK_BIT+1], scan_tick};

  // Test mode lights everything but keeps the scan running underneath.
  zircon_segled_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk    (csi_clk),
    .reset  (rsi_reset),
    .enable (ctrl_en | ctrl_test),
    .index  (index),
    .tick   (scan_tick)
  );

  // Read mux sees the registers before any same-cycle write lands.
  always_comb begin
    rd_mux = '0;
    if (avs_address < DIGITS_A) begin
      rd_mux = {26'b0, digit_q[avs_address[2:0]]};
    end else if (avs_address == ADDR_CTRL) begin
      rd_mux = {30'b0, ctrl_test, ctrl_en};
    end else if (avs_address == ADDR_STAT) begin
      rd_mux = {29'b0, index};
    end
  end

  always_comb begin
    cur_digit  = digit_q[index];
    sel_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      sel_onehot[i] = (index == 3'(i));
    end

    seg_log = 8'h00;
    sel_log = '0;
    if (ctrl_test) begin
      seg_log = 8'hFF;
      sel_log = {DIGITS{1'b1}};
    end else if (!ctrl_en) begin
      seg_log = 8'h00;
      sel_log = '0;
    end else if (cur_digit[DIG_BLANK_BIT]) begin
      seg_log = 8'h00;
      sel_log = sel_onehot;
    end else begin
      seg_log = {cur_digit[DIG_DP_BIT], hex_to_seg(cur_digit[DIG_VAL_MSB:0])};
      sel_log = sel_onehot;
    end

    seg_d = SEG_ACTIVE_LOW ? ~seg_log : seg_log;
    sel_d = SEL_ACTIVE_LOW ? ~sel_log : sel_log;
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      for (int i = 0; i < 8; i++) begin
        digit_q[i] <= DIG_RESET;
      end
      ctrl_en      <= 1'b1;
      ctrl_test    <= 1'b0;
      avs_readdata <= '0;
      coe_seg      <= SEG_OFF;
      coe_sel      <= SEL_OFF;
    end else begin
      if (avs_read) begin
        avs_readdata <= rd_mux;
      end
      if (avs_write) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (avs_address == 4'(i)) begin
            digit_q[i] <= avs_writedata[DIG_BLANK_BIT:0];
          end
        end
        if (avs_address == ADDR_CTRL) begin
          ctrl_en   <= avs_writedata[CTRL_EN_BIT];
          ctrl_test <= avs_writedata[CTRL_TEST_BIT];
        end
      end
      coe_seg <= seg_d;
      coe_sel <= sel_d;
    end
  end

endmodule
